regfile_ckpt: RTL

//   Parametrised multi-port register file, successor to the 32-bit enable/reset register.

---
 rtl/regfile_ckpt_pkg.sv | 22 ++
 rtl/reg_word.sv | 36 +++
 rtl/regfile_ckpt.sv | 104 ++++++++++
 3 files changed

// File: rtl/regfile_ckpt_pkg.sv
// rtl/regfile_ckpt_pkg.sv - shared sizing helpers for the checkpointed register file
package regfile_ckpt_pkg;

    localparam int BYTE_W = 8;

    // Address width for a given depth; never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'(1) << r) < 32'(n)) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int byte_count(input int width);
        return width / BYTE_W;
    endfunction

endpackage

// File: rtl/reg_word.sv
// rtl/reg_word.sv - one register word with per-byte write enable and full-word load
module reg_word
    import regfile_ckpt_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [WIDTH/8-1:0]      be_i,
    input  logic [WIDTH-1:0]        wr_data_i,
    input  logic                    load_i,
    input  logic [WIDTH-1:0]        load_data_i,
    output logic [WIDTH-1:0]        q_o
);

    logic [WIDTH-1:0] word_q;

    // A full-word load (checkpoint/restore copy) wins over byte writes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            word_q <= RESET_VAL;
        end else if (load_i) begin
            word_q <= load_data_i;
        end else begin
            for (int b = 0; b < WIDTH / BYTE_W; b++) begin
                if (be_i[b]) begin
                    word_q[b*BYTE_W +: BYTE_W] <= wr_data_i[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign q_o = word_q;

endmodule

// File: rtl/regfile_ckpt.sv
// rtl/regfile_ckpt.sv - multi-port byte-masked register file with one-deep checkpoint shadow bank
module regfile_ckpt
    import regfile_ckpt_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 32,
    parameter int               NUM_READ  = 2,
    parameter int               ZERO_REG  = 1,
    parameter int               BYPASS    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              AW        = clog2(DEPTH),
    localparam int              NB        = byte_count(WIDTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [AW-1:0]               wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic [NB-1:0]               wr_be,
    input  logic [NUM_READ*AW-1:0]      rd_addr,
    output logic [NUM_READ*WIDTH-1:0]   rd_data,
    input  logic                        checkpoint,
    input  logic                        restore,
    output logic                        ckpt_valid
);

    logic [WIDTH-1:0] live_q   [DEPTH];
    logic [WIDTH-1:0] shadow_q [DEPTH];
    logic             ckpt_valid_q;
    logic             ckpt_valid_d;
    logic             restore_ok;
    logic             ckpt_take;
    logic             wr_ok;

    assign restore_ok = restore && ckpt_valid_q;
    assign ckpt_take  = checkpoint && !restore_ok;
    assign wr_ok      = wr_en && !restore_ok && (32'(wr_addr) < DEPTH)
                        && !((ZERO_REG != 0) && (wr_addr == '0));

    assign ckpt_valid_d = ckpt_valid_q || ckpt_take;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ckpt_valid_q <= 1'b0;
        end else begin
            ckpt_valid_q <= ckpt_valid_d;
        end
    end

    assign ckpt_valid = ckpt_valid_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [NB-1:0] live_be;
        assign live_be = (wr_ok && (wr_addr == AW'(i))) ? wr_be : '0;

        reg_word #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_live (
            .clk         (clk),
            .resetn      (reset),
            .be_i        (live_be),
            .wr_data_i   (wr_data),
            .load_i      (restore_ok),
            .load_data_i (shadow_q[i]),
            .q_o         (live_q[i])
        );

        // Shadow copies the live word as it stood before this edge's write.
        reg_word #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_shadow (
            .clk         (clk),
            .resetn      (reset),
            .be_i        ('0),
            .wr_data_i   (wr_data),
            .load_i      (ckpt_take),
            .load_data_i (live_q[i]),
            .q_o         (shadow_q[i])
        );
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] word;

        assign addr = rd_addr[p*AW +: AW];

        always_comb begin
            word = '0;
            if (32'(addr) < DEPTH) begin
                word = live_q[addr];
                if ((BYPASS != 0) && wr_en && !restore_ok && (addr == wr_addr)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (wr_be[b]) begin
                            word[b*BYTE_W +: BYTE_W] = wr_data[b*BYTE_W +: BYTE_W];
                        end
                    end
                end
            end
            if ((ZERO_REG != 0) && (addr == '0)) begin
                word = '0;
            end
        end

        assign rd_data[p*WIDTH +: WIDTH] = word;
    end

endmodule
